// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register: one output stage plus one skid entry, so fetch sees a
// registered ready. Supports flush and a saturating count of decode stall cycles.
module if_id_pipe_reg #(
  parameter int FMT_W = 2,
  parameter int OPC_W = 4,
  parameter int REG_W = 3,
  parameter int IMM_W = 3,
  parameter int JMP_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [FMT_W-1:0] format_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic [REG_W-1:0] reg1_i,
  input  logic [REG_W-1:0] reg2_i,
  input  logic [REG_W-1:0] regD_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic             immFlag_i,
  input  logic [JMP_W-1:0] jmpLoc_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [FMT_W-1:0] format_o,
  output logic [OPC_W-1:0] opcode_o,
  output logic [REG_W-1:0] reg1_o,
  output logic [REG_W-1:0] reg2_o,
  output logic [REG_W-1:0] regD_o,
  output logic [IMM_W-1:0] imm_o,
  output logic             immFlag_o,
  output logic [JMP_W-1:0] jmpLoc_o,
  input  logic             flush_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // ready_o is a pure function of registered state (skid empty), never of ready_i.
  logic             skid_valid;
  logic [FMT_W-1:0] skid_format;
  logic [OPC_W-1:0] skid_opcode;
  logic [REG_W-1:0] skid_reg1;
  logic [REG_W-1:0] skid_reg2;
  logic [REG_W-1:0] skid_regd;
  logic [IMM_W-1:0] skid_imm;
  logic             skid_imm_flag;
  logic [JMP_W-1:0] skid_jmp_loc;

  logic acc_in;
  logic acc_out;
  logic out_free;
  logic take_skid;
  logic take_in;
  logic park_in;

  assign ready_o = !skid_valid;
  assign acc_in  = valid_i && ready_o;
  assign acc_out = valid_o && ready_i;

  always_comb begin
    out_free  = !valid_o || acc_out;
    take_skid = !flush_i && out_free && skid_valid;
    take_in   = !flush_i && out_free && !skid_valid && acc_in;
    park_in   = !flush_i && !out_free && acc_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush_i) begin
      valid_o    <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      valid_o    <= skid_valid || acc_in;
      skid_valid <= 1'b0;
    end else if (acc_in) begin
      skid_valid <= 1'b1;
    end
  end

  // Output payload only moves when a new instruction lands; otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      format_o  <= '0;
      opcode_o  <= '0;
      reg1_o    <= '0;
      reg2_o    <= '0;
      regD_o    <= '0;
      imm_o     <= '0;
      immFlag_o <= 1'b0;
      jmpLoc_o  <= '0;
    end else if (take_skid) begin
      format_o  <= skid_format;
      opcode_o  <= skid_opcode;
      reg1_o    <= skid_reg1;
      reg2_o    <= skid_reg2;
      regD_o    <= skid_regd;
      imm_o     <= skid_imm;
      immFlag_o <= skid_imm_flag;
      jmpLoc_o  <= skid_jmp_loc;
    end else if (take_in) begin
      format_o  <= format_i;
      opcode_o  <= opcode_i;
      reg1_o    <= reg1_i;
      reg2_o    <= reg2_i;
      regD_o    <= regD_i;
      imm_o     <= imm_i;
      immFlag_o <= immFlag_i;
      jmpLoc_o  <= jmpLoc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_format   <= '0;
      skid_opcode   <= '0;
      skid_reg1     <= '0;
      skid_reg2     <= '0;
      skid_regd     <= '0;
      skid_imm      <= '0;
      skid_imm_flag <= 1'b0;
      skid_jmp_loc  <= '0;
    end else if (park_in) begin
      skid_format   <= format_i;
      skid_opcode   <= opcode_i;
      skid_reg1     <= reg1_i;
      skid_reg2     <= reg2_i;
      skid_regd     <= regD_i;
      skid_imm      <= imm_i;
      skid_imm_flag <= immFlag_i;
      skid_jmp_loc  <= jmpLoc_i;
    end
  end

  // Flush does not clear the counter; only reset does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (valid_o && !ready_i && !flush_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule
